sram_arb: RTL

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/buspirate_pkg.sv | 16 +
 rtl/sram_spi_shifter.sv | 71 +++++++
 rtl/sram_arb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/buspirate_pkg.sv
// Shared types and constants for the serial SRAM arbiter: FSM states, SPI SRAM
// command bytes and the frame length at the default 8-bit data width.
package buspirate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } arb_state_e;

    localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
    localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;
    localparam int         FRAME_BITS     = 40;

endpackage

// File: rtl/sram_spi_shifter.sv
// SPI mode-0 frame engine: MSB-first frame shift register, clock phase toggle,
// bit counter and capture of the trailing data bits from MISO.
module sram_spi_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_W    = 32 + DATA_WIDTH
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [FRAME_W-1:0]    frame_i,
    input  logic                  shift_en_i,
    input  logic                  miso_i,
    output logic                  mosi_o,
    output logic                  phase_o,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] rx_data_o
);
    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic                  phase_q, phase_d;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-2:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rx_full;
    logic                  in_data;

    // rx_full already contains the bit being sampled this cycle, so the
    // complete word is available on the same edge that ends the frame.
    assign rx_full   = {rx_q, miso_i};
    assign in_data   = (bit_q >= CNT_W'(FRAME_W - DATA_WIDTH));
    assign mosi_o    = frame_q[FRAME_W-1];
    assign phase_o   = phase_q;
    assign last_o    = shift_en_i & phase_q & (bit_q == CNT_W'(FRAME_W - 1));
    assign rx_data_o = rx_full;

    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        if (load_i) begin
            frame_d = frame_i;
            phase_d = 1'b0;
            bit_d   = '0;
        end else if (shift_en_i) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                frame_d = {frame_q[FRAME_W-2:0], 1'b0};
                bit_d   = bit_q + CNT_W'(1);
                if (in_data) begin
                    rx_d = rx_full[DATA_WIDTH-2:0];
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            frame_q <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            rx_q    <= '0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Two-requester arbiter for a serial SPI SRAM; each access is one framed transfer.
// Define SRAM_ARB_FIXED_PRIO_EN to give req0 fixed priority instead of round-robin.
module sram_arb
    import buspirate_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ack,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ack,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  busy,
    output logic                  sram_clock,
    output logic                  sram_cs,
    output logic                  sram_mosi,
    input  logic                  sram_miso
);
    localparam int FRAME_W = 32 + DATA_WIDTH;

    arb_state_e            state_q, state_d;
    logic                  grant_q, we_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;
    logic                  pick, load, shift_last, phase, mosi;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata, rx_data;
    logic [FRAME_W-1:0]    frame;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign pick = ~req0_valid;
`else
    logic last_q;

    // On a tie, serve whichever requester was not granted most recently.
    assign pick = (req0_valid & req1_valid) ? ~last_q : ~req0_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (load) begin
            last_q <= pick;
        end
    end
`endif

    assign sel_we    = pick ? req1_we    : req0_we;
    assign sel_addr  = pick ? req1_addr  : req0_addr;
    assign sel_wdata = pick ? req1_wdata : req0_wdata;
    assign frame     = {(sel_we ? SRAM_CMD_WRITE : SRAM_CMD_READ), 24'(sel_addr), sel_wdata};

    sram_spi_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAME_W    (FRAME_W)
    ) u_shifter (
        .clock_i    (clock),
        .reset_i    (reset),
        .load_i     (load),
        .frame_i    (frame),
        .shift_en_i (state_q == SHIFT),
        .miso_i     (sram_miso),
        .mosi_o     (mosi),
        .phase_o    (phase),
        .last_o     (shift_last),
        .rx_data_o  (rx_data)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        busy     = 1'b1;
        sram_cs  = 1'b0;
        req0_ack = 1'b0;
        req1_ack = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy    = 1'b0;
                sram_cs = 1'b1;
                if (req0_valid | req1_valid) begin
                    load    = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = SHIFT;
            SHIFT: begin
                if (shift_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                sram_cs  = 1'b1;
                req0_ack = ~grant_q;
                req1_ack = grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sram_clock = (state_q == SHIFT) & phase;
    assign sram_mosi  = ~sram_cs & mosi;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                grant_q <= pick;
                we_q    <= sel_we;
            end
            // Read data lands on the edge entering HOLD so it is valid alongside ack.
            if (shift_last && !we_q) begin
                if (grant_q) begin
                    rdata1_q <= rx_data;
                end else begin
                    rdata0_q <= rx_data;
                end
            end
        end
    end

endmodule
